// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer
// 8N1 UART receive front end. The raw rx pin is synchronised and oversampled 16x.
// Start, data and stop bits are resolved by a 2-of-3 vote on ticks 7, 8 and 9.
// Good bytes land in a single-entry holding register with a valid/ren handshake.
// Framing errors and overruns are reported as sticky flags.

module uart_rx_deserializer #(
    parameter int OVS_DIV     = 14,
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic                 rx_ren,
    input  logic                 clr_err,
    output logic [DATA_BITS-1:0] rx_byte,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int DIV_W = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(OVS_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_WAIT_IDLE,
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t                 state_q,     state_d;
    logic [SYNC_STAGES-1:0] sync_q,      sync_d;
    logic                   rxs_prev_q,  rxs_prev_d;
    logic [DIV_W-1:0]       div_cnt_q,   div_cnt_d;
    logic [3:0]             ovs_cnt_q,   ovs_cnt_d;
    logic [1:0]             samp_q,      samp_d;
    logic [IDX_W-1:0]       bit_idx_q,   bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q,     shift_d;
    logic [DATA_BITS-1:0]   rx_byte_q,   rx_byte_d;
    logic                   rx_valid_q,  rx_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q,   overrun_d;
    logic                   busy_q,      busy_d;

    logic rxs;
    logic start_edge;
    logic tick;
    logic bit_end;
    logic vote_now;
    logic vote;
    logic load;

    assign rxs        = sync_q[SYNC_STAGES-1];
    assign start_edge = rxs_prev_q & ~rxs;
    assign tick       = (div_cnt_q == DIV_LAST);
    assign bit_end    = tick && (ovs_cnt_q == 4'd15);
    assign vote_now   = tick && (ovs_cnt_q == 4'd9);
    assign vote       = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs) | (samp_q[1] & rxs);

    // Next-state logic: tick generation, bit voting, frame FSM and holding-register handshake.
    always_comb begin
        state_d     = state_q;
        sync_d      = {sync_q[SYNC_STAGES-2:0], rx};
        rxs_prev_d  = rxs;
        div_cnt_d   = tick ? '0 : div_cnt_q + 1'b1;
        ovs_cnt_d   = tick ? ovs_cnt_q + 4'd1 : ovs_cnt_q;
        samp_d      = samp_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_byte_d   = rx_byte_q;
        rx_valid_d  = rx_valid_q & ~rx_ren;
        frame_err_d = frame_err_q & ~clr_err;
        overrun_d   = overrun_q & ~clr_err;
        load        = 1'b0;

        if (tick && (ovs_cnt_q == 4'd7)) begin
            samp_d[0] = rxs;
        end
        if (tick && (ovs_cnt_q == 4'd8)) begin
            samp_d[1] = rxs;
        end

        case (state_q)
            ST_WAIT_IDLE: begin
                // ovs_cnt doubles as the count of consecutive high ticks here
                if (!rxs) begin
                    ovs_cnt_d = 4'd0;
                end else if (bit_end) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (start_edge) begin
                    state_d   = ST_START;
                    div_cnt_d = '0;
                    ovs_cnt_d = 4'd0;
                end
            end
            ST_START: begin
                if (vote_now && vote) begin
                    state_d = ST_IDLE;
                end else if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                end
            end
            ST_DATA: begin
                if (vote_now) begin
                    shift_d = {vote, shift_q[DATA_BITS-1:1]};
                end
                if (bit_end) begin
                    if (bit_idx_q == IDX_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                // Decide mid stop bit so the next start edge is never missed
                if (vote_now) begin
                    if (vote) begin
                        load    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        ovs_cnt_d   = 4'd0;
                        state_d     = ST_WAIT_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_WAIT_IDLE;
            end
        endcase

        if (load) begin
            if (!rx_valid_q || rx_ren) begin
                rx_byte_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_WAIT_IDLE;
            sync_q      <= '1;
            rxs_prev_q  <= 1'b1;
            div_cnt_q   <= '0;
            ovs_cnt_q   <= 4'd0;
            samp_q      <= 2'b00;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_byte_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            rxs_prev_q  <= rxs_prev_d;
            div_cnt_q   <= div_cnt_d;
            ovs_cnt_q   <= ovs_cnt_d;
            samp_q      <= samp_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign rx_byte   = rx_byte_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer
// Drives 8N1 frames at 64 clk per bit (OVS_DIV=4) and checks received bytes
// against a queue of expected bytes filled as frames are sent.

module tb_uart_rx_deserializer;

    localparam int BIT_CLK = 64;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic       rx_ren;
    logic       clr_err;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int         test_count;
    int         fail_count;
    int         lat_cnt;
    logic [7:0] exp_q[$];

    uart_rx_deserializer #(
        .OVS_DIV    (4),
        .DATA_BITS  (8),
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .rx_ren   (rx_ren),
        .clr_err  (clr_err),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    // 100 MHz free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a hung simulation.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitClk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        test_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input logic push);
        if (push) begin
            exp_q.push_back(data);
        end
        rx = 1'b0;
        waitClk(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            waitClk(BIT_CLK);
        end
        rx = stop_bit;
        waitClk(BIT_CLK);
    endtask

    task automatic idleBits(input int n);
        rx = 1'b1;
        waitClk(n * BIT_CLK);
    endtask

    task automatic peekByte();
        logic [7:0] expected;
        expected = 8'hxx;
        if (exp_q.size() != 0) begin
            expected = exp_q.pop_front();
        end
        checkOutput("peek_valid", {31'd0, rx_valid}, 32'd1);
        checkOutput("peek_byte", {24'd0, rx_byte}, {24'd0, expected});
    endtask

    task automatic consumeByte();
        int         waited;
        logic [7:0] expected;
        waited   = 0;
        expected = 8'hxx;
        while (rx_valid !== 1'b1 && waited < 1500) begin
            waitClk(1);
            waited++;
        end
        checkOutput("rx_valid_wait", {31'd0, rx_valid}, 32'd1);
        if (exp_q.size() != 0) begin
            expected = exp_q.pop_front();
        end
        checkOutput("rx_byte", {24'd0, rx_byte}, {24'd0, expected});
        rx_ren = 1'b1;
        waitClk(1);
        rx_ren = 1'b0;
    endtask

    task automatic pulseClrErr();
        clr_err = 1'b1;
        waitClk(1);
        clr_err = 1'b0;
    endtask

    initial begin
        test_count = 0;
        fail_count = 0;
        rst_n      = 1'b0;
        rx         = 1'b1;
        rx_ren     = 1'b0;
        clr_err    = 1'b0;

        // Reset state
        waitClk(3);
        checkOutput("rst_rx_byte", {24'd0, rx_byte}, 32'd0);
        checkOutput("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        checkOutput("rst_frame_err", {31'd0, frame_err}, 32'd0);
        checkOutput("rst_overrun", {31'd0, overrun}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b1;
        waitClk(100);
        checkOutput("idle_after_reset", {31'd0, busy}, 32'd0);

        // Single frame and start-edge-to-valid latency
        lat_cnt = 0;
        fork
            applyStimulus(8'hA5, 1'b1, 1'b1);
            begin
                while (rx_valid !== 1'b1 && lat_cnt < 1000) begin
                    waitClk(1);
                    lat_cnt++;
                end
            end
        join
        checkOutput("latency_619", {31'd0, (lat_cnt >= 618 && lat_cnt <= 620)}, 32'd1);
        consumeByte();
        checkOutput("ren_clears_valid", {31'd0, rx_valid}, 32'd0);
        checkOutput("a5_frame_err", {31'd0, frame_err}, 32'd0);
        idleBits(1);

        // Short glitch rejected as a false start
        rx = 1'b0;
        waitClk(8);
        rx = 1'b1;
        waitClk(2);
        checkOutput("glitch_busy_high", {31'd0, busy}, 32'd1);
        waitClk(50);
        checkOutput("glitch_busy_low", {31'd0, busy}, 32'd0);
        checkOutput("glitch_no_valid", {31'd0, rx_valid}, 32'd0);
        idleBits(1);

        // Framing error, recovery, then sticky clear
        applyStimulus(8'h3C, 1'b0, 1'b0);
        rx = 1'b0;
        waitClk(2 * BIT_CLK);
        idleBits(2);
        checkOutput("ferr_set", {31'd0, frame_err}, 32'd1);
        checkOutput("ferr_no_valid", {31'd0, rx_valid}, 32'd0);
        fork
            applyStimulus(8'h5A, 1'b1, 1'b1);
            consumeByte();
        join
        checkOutput("ferr_sticky", {31'd0, frame_err}, 32'd1);
        pulseClrErr();
        checkOutput("ferr_cleared", {31'd0, frame_err}, 32'd0);
        idleBits(1);

        // Overrun: second byte dropped while first unread
        applyStimulus(8'h11, 1'b1, 1'b1);
        applyStimulus(8'h22, 1'b1, 1'b0);
        checkOutput("ovr_set", {31'd0, overrun}, 32'd1);
        consumeByte();
        pulseClrErr();
        checkOutput("ovr_cleared", {31'd0, overrun}, 32'd0);
        idleBits(1);

        // Overrun avoided by rx_ren on the load cycle
        applyStimulus(8'h11, 1'b1, 1'b1);
        peekByte();
        fork
            applyStimulus(8'h22, 1'b1, 1'b1);
            begin
                waitClk(618);
                rx_ren = 1'b1;
                waitClk(1);
                rx_ren = 1'b0;
            end
        join
        checkOutput("ren_load_no_ovr", {31'd0, overrun}, 32'd0);
        consumeByte();
        idleBits(1);

        // Back-to-back frames with one stop bit
        fork
            begin
                applyStimulus(8'hFF, 1'b1, 1'b1);
                applyStimulus(8'h00, 1'b1, 1'b1);
                applyStimulus(8'h81, 1'b1, 1'b1);
            end
            begin
                consumeByte();
                consumeByte();
                consumeByte();
            end
        join
        checkOutput("b2b_frame_err", {31'd0, frame_err}, 32'd0);
        checkOutput("b2b_overrun", {31'd0, overrun}, 32'd0);
        idleBits(1);

        // Reset in the middle of data bit 2
        fork
            applyStimulus(8'h00, 1'b1, 1'b0);
            begin
                waitClk(4 * BIT_CLK - BIT_CLK / 2);
                rst_n = 1'b0;
                waitClk(1);
                rst_n = 1'b1;
                checkOutput("midrst_rx_byte", {24'd0, rx_byte}, 32'd0);
                checkOutput("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
                checkOutput("midrst_frame_err", {31'd0, frame_err}, 32'd0);
                checkOutput("midrst_overrun", {31'd0, overrun}, 32'd0);
                checkOutput("midrst_busy", {31'd0, busy}, 32'd1);
            end
        join
        idleBits(1);
        checkOutput("midrst_no_byte", {31'd0, rx_valid}, 32'd0);
        checkOutput("midrst_no_ferr", {31'd0, frame_err}, 32'd0);
        fork
            applyStimulus(8'hC3, 1'b1, 1'b1);
            consumeByte();
        join
        idleBits(1);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
